// File: rtl/cordic_reg_file_if.sv
// Host-side register bus for the CORDIC register file: word address, single-cycle
// read/write strobes, one-cycle-latency read return and the host interrupt line.
interface cordic_reg_file_if #(
  parameter int p_WIDTH      = 32,
  parameter int p_ADDR_WIDTH = 3
);
  logic [p_ADDR_WIDTH-1:0] hostAddr;
  logic                    hostWrEn;
  logic [p_WIDTH-1:0]      hostWrData;
  logic                    hostRdEn;
  logic [p_WIDTH-1:0]      hostRdData;
  logic                    hostRdValid;
  logic                    hostIrq;

  modport master (
    output hostAddr, hostWrEn, hostWrData, hostRdEn,
    input  hostRdData, hostRdValid, hostIrq
  );

  modport slave (
    input  hostAddr, hostWrEn, hostWrData, hostRdEn,
    output hostRdData, hostRdValid, hostIrq
  );
endinterface

// File: rtl/cordic_reg_file.sv
// CORDIC register file: host-visible control/operand/result registers shared with the controller.
// Optional build macro CORDIC_IRQ_STICKY_EN: sticky, host-clearable interrupt status at address 7.
module cordic_reg_file #(
  parameter int p_WIDTH      = 32,
  parameter int p_ADDR_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  cordic_reg_file_if.slave   host,
  output logic [p_WIDTH-1:0] controlRegisterInput,
  output logic [p_WIDTH-1:0] xInput,
  output logic [p_WIDTH-1:0] yInput,
  output logic [p_WIDTH-1:0] zInput,
  input  logic [p_WIDTH-1:0] controlRegisterOutput,
  input  logic               controlRegisterWriteEnable,
  input  logic [p_WIDTH-1:0] xResult,
  input  logic [p_WIDTH-1:0] yResult,
  input  logic [p_WIDTH-1:0] zResult,
  input  logic               interrupt
);

  typedef enum logic [2:0] {
    ADDR_CONTROL    = 3'd0,
    ADDR_X_IN       = 3'd1,
    ADDR_Y_IN       = 3'd2,
    ADDR_Z_IN       = 3'd3,
    ADDR_X_RES      = 3'd4,
    ADDR_Y_RES      = 3'd5,
    ADDR_Z_RES      = 3'd6,
    ADDR_IRQ_STATUS = 3'd7
  } regAddr_e;

  localparam logic [p_WIDTH-1:0] CtrlResetVal = 32'h0001_1FF0;

  logic [p_WIDTH-1:0] ctrlReg;
  logic [p_WIDTH-1:0] xInReg;
  logic [p_WIDTH-1:0] yInReg;
  logic [p_WIDTH-1:0] zInReg;
  logic [p_WIDTH-1:0] xResReg;
  logic [p_WIDTH-1:0] yResReg;
  logic [p_WIDTH-1:0] zResReg;
  logic [p_WIDTH-1:0] irqStatusWord;
  logic [p_WIDTH-1:0] rdMux_p0;
  logic [p_WIDTH-1:0] rdData_p1;
  logic               rdVld_p1;

  logic wrCtrl;
  logic wrX;
  logic wrY;
  logic wrZ;
  logic wrIrq;

  // Controller write-back owns the flag half; the host may only ever touch [15:0],
  // and wins on those bits when both land in the same cycle.
  function automatic logic [p_WIDTH-1:0] mergeControl(
    input logic [p_WIDTH-1:0] cur,
    input logic [p_WIDTH-1:0] wbVal,
    input logic               wbEn,
    input logic [p_WIDTH-1:0] hostVal,
    input logic               hostEn
  );
    logic [p_WIDTH-1:0] res;
    res = wbEn ? wbVal : cur;
    if (hostEn) begin
      res[15:0] = hostVal[15:0];
    end
    return res;
  endfunction

  assign wrCtrl = host.hostWrEn && (host.hostAddr == ADDR_CONTROL);
  assign wrX    = host.hostWrEn && (host.hostAddr == ADDR_X_IN);
  assign wrY    = host.hostWrEn && (host.hostAddr == ADDR_Y_IN);
  assign wrZ    = host.hostWrEn && (host.hostAddr == ADDR_Z_IN);
  assign wrIrq  = host.hostWrEn && (host.hostAddr == ADDR_IRQ_STATUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlReg <= CtrlResetVal;
    end else begin
      ctrlReg <= mergeControl(ctrlReg, controlRegisterOutput, controlRegisterWriteEnable,
                              host.hostWrData, wrCtrl);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xInReg <= '0;
      yInReg <= '0;
      zInReg <= '0;
    end else begin
      if (wrX) xInReg <= host.hostWrData;
      if (wrY) yInReg <= host.hostWrData;
      if (wrZ) zInReg <= host.hostWrData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xResReg <= '0;
      yResReg <= '0;
      zResReg <= '0;
    end else if (controlRegisterWriteEnable) begin
      xResReg <= xResult;
      yResReg <= yResult;
      zResReg <= zResult;
    end
  end

`ifdef CORDIC_IRQ_STICKY_EN
  logic irqStatus;

  // A new pulse outranks a coincident host clear so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      irqStatus <= 1'b0;
    end else if (interrupt) begin
      irqStatus <= 1'b1;
    end else if (wrIrq && host.hostWrData[0]) begin
      irqStatus <= 1'b0;
    end
  end

  assign irqStatusWord = {{(p_WIDTH-1){1'b0}}, irqStatus};
  assign host.hostIrq  = irqStatus;
`else
  logic unusedIrqWr;

  assign unusedIrqWr   = wrIrq;
  assign irqStatusWord = '0;
  assign host.hostIrq  = interrupt;
`endif

  always_comb begin
    rdMux_p0 = '0;
    case (host.hostAddr)
      ADDR_CONTROL:    rdMux_p0 = ctrlReg;
      ADDR_X_IN:       rdMux_p0 = xInReg;
      ADDR_Y_IN:       rdMux_p0 = yInReg;
      ADDR_Z_IN:       rdMux_p0 = zInReg;
      ADDR_X_RES:      rdMux_p0 = xResReg;
      ADDR_Y_RES:      rdMux_p0 = yResReg;
      ADDR_Z_RES:      rdMux_p0 = zResReg;
      ADDR_IRQ_STATUS: rdMux_p0 = irqStatusWord;
      default:         rdMux_p0 = '0;
    endcase
  end

  // p0 -> p1: read data sampled before this edge's writes land, hence pre-write values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdVld_p1  <= 1'b0;
      rdData_p1 <= '0;
    end else begin
      rdVld_p1 <= host.hostRdEn;
      if (host.hostRdEn) begin
        rdData_p1 <= rdMux_p0;
      end
    end
  end

  assign host.hostRdData       = rdData_p1;
  assign host.hostRdValid      = rdVld_p1;
  assign controlRegisterInput  = ctrlReg;
  assign xInput                = xInReg;
  assign yInput                = yInReg;
  assign zInput                = zInReg;

endmodule

// File: tb/tb_cordic_reg_file.sv
// Scoreboard bench for cordic_reg_file: a register model predicts read data at issue
// time, and a monitor pops and compares when hostRdValid should appear.
module tb_cordic_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_reg_file_if hif ();

  logic [31:0] ctrlIn, xIn, yIn, zIn;
  logic [31:0] ctrlOut = '0, xRes = '0, yRes = '0, zRes = '0;
  logic        ctrlWe = 1'b0, irq = 1'b0;

  cordic_reg_file dut (
    .clk                        (clk),
    .rst                        (rst),
    .host                       (hif),
    .controlRegisterInput       (ctrlIn),
    .xInput                     (xIn),
    .yInput                     (yIn),
    .zInput                     (zIn),
    .controlRegisterOutput      (ctrlOut),
    .controlRegisterWriteEnable (ctrlWe),
    .xResult                    (xRes),
    .yResult                    (yRes),
    .zResult                    (zRes),
    .interrupt                  (irq)
  );

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] expQ[$];
  logic [31:0] mCtrl, mX, mY, mZ, mXr, mYr, mZr;
  logic        mIrq;

  task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    case (a)
      3'd0: return mCtrl;
      3'd1: return mX;
      3'd2: return mY;
      3'd3: return mZ;
      3'd4: return mXr;
      3'd5: return mYr;
      3'd6: return mZr;
`ifdef CORDIC_IRQ_STICKY_EN
      default: return {31'b0, mIrq};
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  // Advance one clock, predicting the next register state from the inputs now applied.
  task automatic step();
    logic [31:0] c, x, y, z, xr, yr, zr;
    logic        ir;
    if (hif.hostRdEn && !rst) expQ.push_back(modelRead(hif.hostAddr));
    c = mCtrl; x = mX; y = mY; z = mZ; xr = mXr; yr = mYr; zr = mZr; ir = mIrq;
    if (rst) begin
      c = 32'h0001_1FF0; x = 0; y = 0; z = 0; xr = 0; yr = 0; zr = 0; ir = 0;
    end else begin
      if (ctrlWe) begin
        c = ctrlOut; xr = xRes; yr = yRes; zr = zRes;
      end
      if (hif.hostWrEn) begin
        case (hif.hostAddr)
          3'd0: c[15:0] = hif.hostWrData[15:0];
          3'd1: x = hif.hostWrData;
          3'd2: y = hif.hostWrData;
          3'd3: z = hif.hostWrData;
          default: ;
        endcase
      end
      if (irq) ir = 1'b1;
      else if (hif.hostWrEn && hif.hostAddr == 3'd7 && hif.hostWrData[0]) ir = 1'b0;
    end
    @(posedge clk);
    #1;
    mCtrl = c; mX = x; mY = y; mZ = z; mXr = xr; mYr = yr; mZr = zr; mIrq = ir;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    hif.hostAddr = a; hif.hostWrData = d; hif.hostWrEn = 1'b1;
    step();
    hif.hostWrEn = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    hif.hostAddr = a; hif.hostRdEn = 1'b1;
    step();
    hif.hostRdEn = 1'b0;
  endtask

  // Read-return monitor: validity every cycle, data on valid, hold otherwise.
  always @(posedge clk) begin : mon
    logic        ev;
    logic [31:0] lastRd;
    logic        wasRst;
    ev = hif.hostRdEn && !rst;
    wasRst = rst;
    #1;
    chkVal("rdValid", {31'b0, hif.hostRdValid}, {31'b0, ev});
    if (wasRst) lastRd = 32'h0;
    if (ev) begin
      if (expQ.size() == 0) begin
        chkVal("rdQueue", 32'd0, 32'd1);
      end else begin
        lastRd = expQ.pop_front();
        chkVal("rdData", hif.hostRdData, lastRd);
      end
    end else begin
      chkVal("rdHold", hif.hostRdData, lastRd);
    end
  end

  initial begin
    hif.hostAddr = '0; hif.hostWrEn = 1'b0; hif.hostWrData = '0; hif.hostRdEn = 1'b0;
    mCtrl = 0; mX = 0; mY = 0; mZ = 0; mXr = 0; mYr = 0; mZr = 0; mIrq = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chkVal("rstCtrl", ctrlIn, 32'h0001_1FF0);
    chkVal("rstX", xIn, 32'h0);
    chkVal("rstY", yIn, 32'h0);
    chkVal("rstZ", zIn, 32'h0);
    chkVal("rstIrq", {31'b0, hif.hostIrq}, 32'h0);
    rd(3'd0);
    step();

    wr(3'd0, 32'hFFFF_0F0D);
    chkVal("flagProt", ctrlIn, 32'h0001_0F0D);

    hif.hostAddr = 3'd0; hif.hostWrData = 32'h0000_1F05; hif.hostWrEn = 1'b1;
    ctrlOut = 32'h0040_0000; ctrlWe = 1'b1;
    step();
    hif.hostWrEn = 1'b0; ctrlWe = 1'b0;
    chkVal("collision", ctrlIn, 32'h0040_1F05);
    rd(3'd0);

    wr(3'd1, 32'h1111_1111);
    chkVal("xIn", xIn, 32'h1111_1111);
    wr(3'd2, 32'h2222_2222);
    wr(3'd3, 32'h3333_3333);
    chkVal("yIn", yIn, 32'h2222_2222);
    chkVal("zIn", zIn, 32'h3333_3333);

    hif.hostAddr = 3'd1; hif.hostWrData = 32'hAAAA_5555; hif.hostWrEn = 1'b1; hif.hostRdEn = 1'b1;
    step();
    hif.hostWrEn = 1'b0; hif.hostRdEn = 1'b0;
    chkVal("xInRaw", xIn, 32'hAAAA_5555);
    rd(3'd1);

    xRes = 32'h1234_5678; yRes = 32'h0000_0001; zRes = 32'hFFFF_FFFF;
    ctrlOut = 32'h0040_1F04; ctrlWe = 1'b1;
    step();
    ctrlWe = 1'b0; xRes = 32'h0BAD_0BAD; yRes = 32'h0; zRes = 32'h5A5A_5A5A;
    chkVal("xResModel", mXr, 32'h1234_5678);
    rd(3'd4); rd(3'd5); rd(3'd6);
    wr(3'd4, 32'hDEAD_BEEF);
    rd(3'd4);
    rd(3'd7);

    wr(3'd0, 32'h0000_1F01);
    chkVal("startSet", {31'b0, ctrlIn[0]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chkVal("startHold", {31'b0, ctrlIn[0]}, 32'd1);
    end
    ctrlOut = 32'h0000_1F00; ctrlWe = 1'b1;
    chkVal("startPreWb", {31'b0, ctrlIn[0]}, 32'd1);
    step();
    ctrlWe = 1'b0;
    chkVal("startClr", ctrlIn, 32'h0000_1F00);
    wr(3'd0, 32'h0000_0002);
    step();
    chkVal("stopHold", ctrlIn, 32'h0000_0002);

    rst = 1'b1; hif.hostAddr = 3'd1; hif.hostRdEn = 1'b1;
    step();
    rst = 1'b0; hif.hostRdEn = 1'b0;
    chkVal("rst2Ctrl", ctrlIn, 32'h0001_1FF0);
    chkVal("rst2X", xIn, 32'h0);
    step();

`ifdef CORDIC_IRQ_STICKY_EN
    irq = 1'b1;
    step();
    irq = 1'b0;
    chkVal("irqSet", {31'b0, hif.hostIrq}, 32'd1);
    step(); step();
    chkVal("irqSticky", {31'b0, hif.hostIrq}, 32'd1);
    rd(3'd7);
    wr(3'd7, 32'h1);
    chkVal("irqClr", {31'b0, hif.hostIrq}, 32'd0);
    irq = 1'b1;
    wr(3'd7, 32'h1);
    irq = 1'b0;
    chkVal("irqSetWins", {31'b0, hif.hostIrq}, 32'd1);
    rd(3'd7);
`else
    irq = 1'b1;
    #1;
    chkVal("irqPass1", {31'b0, hif.hostIrq}, 32'd1);
    irq = 1'b0;
    #1;
    chkVal("irqPass0", {31'b0, hif.hostIrq}, 32'd0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7);
`endif

    for (int i = 0; i < 60; i++) begin
      hif.hostAddr   = 3'($urandom_range(0, 7));
      hif.hostWrData = $urandom;
      hif.hostWrEn   = 1'($urandom_range(0, 1));
      hif.hostRdEn   = 1'($urandom_range(0, 1));
      ctrlWe         = ($urandom_range(0, 3) == 0);
      ctrlOut        = $urandom;
      xRes = $urandom; yRes = $urandom; zRes = $urandom;
      irq            = ($urandom_range(0, 7) == 0);
      step();
      chkVal("rndCtrl", ctrlIn, mCtrl);
`ifdef CORDIC_IRQ_STICKY_EN
      chkVal("rndIrq", {31'b0, hif.hostIrq}, {31'b0, mIrq});
`endif
    end
    hif.hostWrEn = 1'b0; hif.hostRdEn = 1'b0; ctrlWe = 1'b0; irq = 1'b0;
    for (int a = 0; a < 8; a++) rd(3'(a));
    chkVal("rndX", xIn, mX);
    chkVal("rndZ", zIn, mZ);
    step(); step();
    chkVal("queueEmpty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/cordic_reg_file.md
CORDIC_REG_FILE -- requirements
Module: cordic_reg_file

Interface
REQ-001 Parameter p_WIDTH, default 32, operand/result/register width; only 32 is supported.
REQ-002 Parameter p_ADDR_WIDTH, default 3, host word-address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; the ports are:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- hostAddr  in  3  word address
- hostWrEn  in  1  host write strobe, single cycle
- hostWrData  in  32  host write data
- hostRdEn  in  1  host read strobe, single cycle
- hostRdData  out  32  read data
- hostRdValid  out  1  read data valid
- hostIrq  out  1  interrupt to host
- controlRegisterInput  out  32  control register as seen by the controller
- xInput, yInput, zInput  out  32 each  operand registers
- controlRegisterOutput  in  32  controller write-back value
- controlRegisterWriteEnable  in  1  controller write-back strobe
- xResult, yResult, zResult  in  32 each  controller datapath values
- interrupt  in  1  controller interrupt pulse

Function
REQ-004 Address map SHALL be: 0 CONTROL, 1 X_IN, 2 Y_IN, 3 Z_IN, 4 X_RES, 5 Y_RES, 6 Z_RES, 7 IRQ_STATUS.
REQ-005 A host write to CONTROL SHALL update bits [15:0] only; bits [31:16] (flags) SHALL be host read-only.
REQ-006 A controller write-back SHALL load all 32 bits of CONTROL from controlRegisterOutput.
REQ-007 Host write to CONTROL and controller write-back in the same cycle: bits [31:16] from the controller, bits [15:0] from the host.
REQ-008 Start (bit 0) and stop (bit 1) SHALL be held until the next controller write-back, which clears them by overwrite.
REQ-009 Host writes to X_IN/Y_IN/Z_IN SHALL be accepted in every cycle and take effect on the next edge.
REQ-010 X_RES/Y_RES/Z_RES SHALL capture xResult/yResult/zResult on every cycle with controlRegisterWriteEnable high, and hold otherwise.
REQ-011 Writes to addresses 4-6 SHALL be ignored.
REQ-012 Reads: one-cycle latency; hostRdValid high the cycle after hostRdEn, otherwise low; hostRdData holds its last value when hostRdValid is low.
REQ-013 A read in the same cycle as a write to the same address SHALL return the pre-write value.
REQ-014 Address 7 SHALL read 0 and ignore writes when the Configuration feature is absent.
REQ-015 controlRegisterInput, xInput, yInput and zInput SHALL be driven directly from the registers, with no added latency.

Reset
REQ-016 When rst is high at an edge: CONTROL=0x0001_1FF0, X_IN/Y_IN/Z_IN=0, X_RES/Y_RES/Z_RES=0, hostRdValid=0, hostRdData=0, IRQ status=0, hostIrq=0.
REQ-017 Reset SHALL take priority over all host and controller accesses in the same cycle; a read pending at reset is dropped, so no hostRdValid follows.

Configuration
REQ-018 Macro CORDIC_IRQ_STICKY_EN SHALL select the interrupt behaviour:
- Defined: an interrupt pulse sets IRQ_STATUS[0]; hostIrq = IRQ_STATUS[0], registered. A host write of 1 to bit 0 at address 7 clears it; a set in the same cycle wins over the clear.
- Undefined: hostIrq = interrupt, combinational pass-through with no storage.

Verification
REQ-019 Reset check: assert rst for 1 cycle, then read addr 0 -> hostRdData=0x0001_1FF0 with hostRdValid exactly 1 cycle after hostRdEn.
REQ-020 Flag protection: write 0xFFFF_0F0D to addr 0, no write-back -> controlRegisterInput=0x0001_0F0D.
REQ-021 Collision: host writes 0x0000_1F05 while the controller writes back 0x0040_0000 in the same cycle -> CONTROL=0x0040_1F05.
REQ-022 Result capture: xResult=0x1234_5678, yResult=0x0000_0001, zResult=0xFFFF_FFFF with 1-cycle write-back -> reads of addrs 4/5/6 return those values after the inputs change.
REQ-023 Start clear: write 0x0000_1F01, then write-back 0x0000_1F00 -> bit 0 is 1 until the write-back edge, then 0.
REQ-024 With CORDIC_IRQ_STICKY_EN defined: 1-cycle interrupt pulse -> hostIrq stays 1; write 1 to addr 7 -> hostIrq 0 next cycle; pulse coincident with the clear -> hostIrq stays 1.
